hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Reader-side counterpart to the GRF write port. It tracks in-flight register writes in the E, M and W stages.
- For the D-stage reads on rs and rt, it decides whether to stall, which stage to forward from, and whether the forwarded data is ready.
- Sits beside the D/E/M/W pipeline registers. It drives the D-stage stall/bubble and the forwarding mux selects.
- The W-stage match is essential: the GRF commits one delay after posedge clk, so a same-cycle read of the GRF returns the stale value.

Parameters:
- TNEW_W, 2, width of the Tnew/Tuse fields.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all entries and the counter
- d_valid  input  1  D stage holds a real instruction
- d_rs  input  5  D-stage source register 1
- d_rt  input  5  D-stage source register 2
- d_tuse_rs  input  2  cycles until rs is consumed (0..2); 3 = rs unused
- d_tuse_rt  input  2  same for rt
- d_a3  input  5  D-stage destination register (0 = no write)
- d_tnew  input  2  cycles after E entry until result exists (ALU 1, load 2, link 0)
- stall  output  1  freeze PC and IF/ID; insert a bubble into E
- fwd_rs_sel  output  2  0 = GRF, 1 = E, 2 = M, 3 = W
- fwd_rs_rdy  output  1  selected source holds final data now
- fwd_rt_sel  output  2  same for rt
- fwd_rt_rdy  output  1  same for rt
- e_a3, m_a3, w_a3  output  5 each  destination of each stage entry (0 = none)
- stall_cnt  output  CNT_W  number of stalled cycles since reset

Behaviour:
- State is three entries, E, M and W, each holding {a3[4:0], tnew[1:0]}.
- The W entry's tnew is always 0.
- Reset (asynchronous, immediate, no clock required):
  - all entries become {0,0}, so stall=0, all sel=0, all rdy=0, stall_cnt=0.
- Each posedge clk when reset=0:
  - W <= M.
  - M <= {E.a3, E.tnew==0 ? 0 : E.tnew-1}; tnew saturates at 0 and never wraps.
  - E <= (d_valid && !stall) ? {d_a3, d_tnew} : {0,0}. A stall always loads a bubble.
  - stall_cnt <= stall_cnt + stall; it wraps modulo 2^CNT_W.
- Per-source lookup (combinational, identical for rs and rt; shown for rs):
  - If rs==0, or tuse==3, or d_valid==0: no match, sel=0, rdy=0.
  - Otherwise the match is the youngest entry with a3==rs, searched in order E, then M, then W. Entries with a3==0 never match.
  - sel is the matched stage (1/2/3), or 0 if there is no match.
  - rdy = 1 iff a match exists and its tnew==0.
  - The source requests a stall iff a match exists and its tnew > tuse.
- stall = the rs request OR the rt request. The outputs depend only on the current entries and the D inputs; there are no internal registers on the outputs.
- An older entry matching the same register is ignored when a younger one matches. This holds even if the younger one is stalling.
- While stall=1, the D inputs are held by the upstream logic. The decision is re-evaluated every cycle.
- Stall length never exceeds 2 cycles, since the maximum tnew is 2 and the minimum tuse is 0.
- Reset asserted mid-stall: stall drops immediately. After release, the pending D instruction re-evaluates against empty entries.
- The block never writes the GRF; it only observes the write stream.

Test Plan:
- Reset:
  - assert reset with no clock edge -> stall=0, all sel=0, all rdy=0, e/m/w_a3=0, stall_cnt=0.
- ALU dependency:
  - issue d_a3=3, d_tnew=1; next cycle d_rs=3, tuse_rs=0 -> stall=1 for exactly 1 cycle, E holds a bubble, stall_cnt=1.
  - following cycle -> stall=0, fwd_rs_sel=2, fwd_rs_rdy=1.
- Load-use:
  - issue d_a3=5, d_tnew=2; next cycle d_rt=5, tuse_rt=1 -> stall=1 for 1 cycle.
  - then stall=0, fwd_rt_sel=2, fwd_rt_rdy=0.
  - one cycle later -> fwd_rt_sel=3, fwd_rt_rdy=1.
- $0 and unused sources:
  - d_a3=0 with d_tnew=2, then d_rs=0 tuse 0 -> no stall, sel=0.
  - d_rs=7 with tuse=3 while E.a3=7 -> no stall, sel=0.
- Youngest wins:
  - E={4,0} and M={4,1}; read rs=4 with tuse=0 -> sel=1, rdy=1, stall=0.
  - E={4,2} and M={4,0}; read rs=4 with tuse=1 -> stall=1. The M match is not used.
- Async reset mid-stall:
  - during the load-use stall, pulse reset between clock edges -> stall drops in the same cycle, entries and stall_cnt clear.
  - after release, the held D instruction proceeds with no stall and sel=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers in flight through E/M/W and resolves D-stage
// read hazards: stall request, forwarding source select and data-ready flag.
module hazard_scoreboard #(
    parameter int TNEW_W = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [4:0]        d_a3,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic              stall,
    output logic [1:0]        fwd_rs_sel,
    output logic              fwd_rs_rdy,
    output logic [1:0]        fwd_rt_sel,
    output logic              fwd_rt_rdy,
    output logic [4:0]        e_a3,
    output logic [4:0]        m_a3,
    output logic [4:0]        w_a3,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [4:0]        e_a3_reg, m_a3_reg, w_a3_reg;
    logic [TNEW_W-1:0] e_tnew_reg, m_tnew_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    // One identical lookup per source: index 0 is rs, index 1 is rt.
    for (genvar gi = 0; gi < 2; gi++) begin : lookup
        logic [4:0]        src;
        logic [TNEW_W-1:0] tuse;
        logic [1:0]        sel;
        logic              rdy;
        logic              req;

        assign src  = (gi == 0) ? d_rs : d_rt;
        assign tuse = (gi == 0) ? d_tuse_rs : d_tuse_rt;

        // Youngest match wins; src != 0 already excludes empty (a3 == 0) entries.
        always_comb begin
            sel = 2'd0;
            rdy = 1'b0;
            req = 1'b0;
            if (d_valid && (src != 5'd0) && (tuse != '1)) begin
                if (e_a3_reg == src) begin
                    sel = 2'd1;
                    rdy = (e_tnew_reg == '0);
                    req = (e_tnew_reg > tuse);
                end else if (m_a3_reg == src) begin
                    sel = 2'd2;
                    rdy = (m_tnew_reg == '0);
                    req = (m_tnew_reg > tuse);
                end else if (w_a3_reg == src) begin
                    sel = 2'd3;
                    rdy = 1'b1;
                    req = 1'b0;
                end
            end
        end
    end

    assign stall      = lookup[0].req | lookup[1].req;
    assign fwd_rs_sel = lookup[0].sel;
    assign fwd_rs_rdy = lookup[0].rdy;
    assign fwd_rt_sel = lookup[1].sel;
    assign fwd_rt_rdy = lookup[1].rdy;
    assign e_a3       = e_a3_reg;
    assign m_a3       = m_a3_reg;
    assign w_a3       = w_a3_reg;
    assign stall_cnt  = stall_cnt_reg;

    // W's result is always available, so only its destination is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_a3_reg      <= 5'd0;
            e_tnew_reg    <= '0;
            m_a3_reg      <= 5'd0;
            m_tnew_reg    <= '0;
            w_a3_reg      <= 5'd0;
            stall_cnt_reg <= '0;
        end else begin
            w_a3_reg   <= m_a3_reg;
            m_a3_reg   <= e_a3_reg;
            m_tnew_reg <= (e_tnew_reg == '0) ? '0 : e_tnew_reg - TNEW_W'(1);
            if (d_valid && !stall) begin
                e_a3_reg   <= d_a3;
                e_tnew_reg <= d_tnew;
            end else begin
                e_a3_reg   <= 5'd0;
                e_tnew_reg <= '0;
            end
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(stall);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios with literal
// expectations, then random traffic checked every cycle against an issue-history model.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [4:0]  d_rs, d_rt, d_a3;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        stall;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic        fwd_rs_rdy, fwd_rt_rdy;
    logic [4:0]  e_a3, m_a3, w_a3;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    hazard_scoreboard #(.TNEW_W(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_a3(d_a3), .d_tnew(d_tnew), .stall(stall),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rs_rdy(fwd_rs_rdy),
        .fwd_rt_sel(fwd_rt_sel), .fwd_rt_rdy(fwd_rt_rdy),
        .e_a3(e_a3), .m_a3(m_a3), .w_a3(w_a3), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of what entered E on each past edge (index 0 = most recent).
    // An instruction of age k has tnew reduced by k-1, floored at 0; age 3 is always ready.
    logic [4:0] q_a3[$];
    int         q_tnew[$];
    int         m_cnt = 0;
    bit         m_stall_edge = 0;

    function automatic void lookup(input logic [4:0] src, input int tuse,
                                   output int sel, output int rdy, output int req);
        int rem;
        sel = 0; rdy = 0; req = 0;
        if (d_valid && src != 0 && tuse != 3) begin
            for (int age = 1; age <= 3; age++) begin
                if (sel == 0 && age <= q_a3.size() && q_a3[age-1] == src) begin
                    rem = (age == 3) ? 0 : q_tnew[age-1] - (age - 1);
                    if (rem < 0) rem = 0;
                    sel = age;
                    rdy = (rem == 0);
                    req = (rem > tuse);
                end
            end
        end
    endfunction

    function automatic int model_stall();
        int s0, r0, q0, s1, r1, q1;
        lookup(d_rs, int'(d_tuse_rs), s0, r0, q0);
        lookup(d_rt, int'(d_tuse_rt), s1, r1, q1);
        return (q0 | q1);
    endfunction

    function automatic int hist_a3(input int idx);
        return (idx < q_a3.size()) ? int'(q_a3[idx]) : 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_a3.delete();
            q_tnew.delete();
            m_cnt = 0;
            m_stall_edge = 0;
        end else begin
            m_stall_edge = (model_stall() != 0);
            q_a3.push_front((d_valid && !m_stall_edge) ? d_a3 : 5'd0);
            q_tnew.push_front((d_valid && !m_stall_edge) ? int'(d_tnew) : 0);
            if (q_a3.size() > 3) begin
                void'(q_a3.pop_back());
                void'(q_tnew.pop_back());
            end
            m_cnt = m_cnt + (m_stall_edge ? 1 : 0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int s0, r0, q0, s1, r1, q1;
        if (cmp_en) begin
            lookup(d_rs, int'(d_tuse_rs), s0, r0, q0);
            lookup(d_rt, int'(d_tuse_rt), s1, r1, q1);
            check("m_stall",  int'(stall),      q0 | q1);
            check("m_rs_sel", int'(fwd_rs_sel), s0);
            check("m_rs_rdy", int'(fwd_rs_rdy), r0);
            check("m_rt_sel", int'(fwd_rt_sel), s1);
            check("m_rt_rdy", int'(fwd_rt_rdy), r1);
            check("m_e_a3",   int'(e_a3),       hist_a3(0));
            check("m_m_a3",   int'(m_a3),       hist_a3(1));
            check("m_w_a3",   int'(w_a3),       hist_a3(2));
            check("m_cnt",    int'(stall_cnt),  m_cnt);
        end
    end

    task automatic set_d(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic [1:0] trt,
                         input logic [4:0] a3, input logic [1:0] tn);
        d_valid = v; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
        d_a3 = a3; d_tnew = tn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        set_d(0, 0, 3, 0, 3, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        set_d(0, 0, 3, 0, 3, 0, 0);
        #2;
        check("rst_stall",  int'(stall), 0);
        check("rst_rs_sel", int'(fwd_rs_sel), 0);
        check("rst_rt_rdy", int'(fwd_rt_rdy), 0);
        check("rst_e_a3",   int'(e_a3), 0);
        check("rst_w_a3",   int'(w_a3), 0);
        check("rst_cnt",    int'(stall_cnt), 0);
        cmp_en = 1;
        tick();
        reset = 1'b0;

        // ALU result consumed immediately
        set_d(1, 0, 3, 0, 3, 3, 1); tick();
        set_d(1, 3, 0, 0, 3, 0, 0); #2;
        check("alu_stall",  int'(stall), 1);
        check("alu_sel_e",  int'(fwd_rs_sel), 1);
        tick(); #1;
        check("alu_go",     int'(stall), 0);
        check("alu_sel_m",  int'(fwd_rs_sel), 2);
        check("alu_rdy",    int'(fwd_rs_rdy), 1);
        check("alu_bubble", int'(e_a3), 0);
        check("alu_cnt",    int'(stall_cnt), 1);
        flush();

        // load-use
        set_d(1, 0, 3, 0, 3, 5, 2); tick();
        set_d(1, 0, 3, 5, 1, 0, 0); #2;
        check("ld_stall",  int'(stall), 1);
        tick(); #1;
        check("ld_go",     int'(stall), 0);
        check("ld_sel_m",  int'(fwd_rt_sel), 2);
        check("ld_rdy_m",  int'(fwd_rt_rdy), 0);
        check("ld_cnt",    int'(stall_cnt), 2);
        tick(); #1;
        check("ld_sel_w",  int'(fwd_rt_sel), 3);
        check("ld_rdy_w",  int'(fwd_rt_rdy), 1);
        flush();

        // $0 and unused sources
        set_d(1, 0, 3, 0, 3, 0, 2); tick();
        set_d(1, 0, 0, 0, 3, 0, 0); #2;
        check("r0_stall", int'(stall), 0);
        check("r0_sel",   int'(fwd_rs_sel), 0);
        set_d(1, 0, 3, 0, 3, 7, 2); tick();
        set_d(1, 7, 3, 0, 3, 0, 0); #2;
        check("unused_e_a3", int'(e_a3), 7);
        check("unused_stall", int'(stall), 0);
        check("unused_sel",   int'(fwd_rs_sel), 0);
        flush();

        // youngest match wins
        set_d(1, 0, 3, 0, 3, 4, 2); tick();
        set_d(1, 0, 3, 0, 3, 4, 0); tick();
        set_d(1, 4, 0, 0, 3, 0, 0); #2;
        check("yw_sel",   int'(fwd_rs_sel), 1);
        check("yw_rdy",   int'(fwd_rs_rdy), 1);
        check("yw_stall", int'(stall), 0);
        flush();
        set_d(1, 0, 3, 0, 3, 4, 0); tick();
        set_d(1, 0, 3, 0, 3, 4, 2); tick();
        set_d(1, 4, 1, 0, 3, 0, 0); #2;
        check("yo_stall", int'(stall), 1);
        check("yo_sel",   int'(fwd_rs_sel), 1);
        flush();

        // async reset in the middle of a load-use stall
        set_d(1, 0, 3, 0, 3, 5, 2); tick();
        set_d(1, 0, 3, 5, 1, 0, 0); #2;
        check("ar_pre_stall", int'(stall), 1);
        #1 reset = 1'b1;
        #1;
        check("ar_stall", int'(stall), 0);
        check("ar_cnt",   int'(stall_cnt), 0);
        check("ar_e_a3",  int'(e_a3), 0);
        check("ar_m_a3",  int'(m_a3), 0);
        reset = 1'b0;
        #1;
        check("ar_held_stall", int'(stall), 0);
        check("ar_held_sel",   int'(fwd_rt_sel), 0);
        tick();
        flush();

        // random traffic; D inputs are held while the model says stall
        for (int i = 0; i < 2000; i++) begin
            if (!m_stall_edge) begin
                set_d($urandom_range(0, 9) < 8,
                      5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
            end
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
